// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// state encoding, default widths and per-stage control widths.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package pipe_pkg;

  localparam int WORD_W     = `WORD_WIDTH;
  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Control bundle width carried by each stage boundary of the ARM core.
  localparam int CTRL_W_IF_ID  = 0;
  localparam int CTRL_W_ID_EX  = 8;
  localparam int CTRL_W_EX_MEM = 3;
  localparam int CTRL_W_MEM_WB = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid flag plus pc/data/ctrl fields.
// Priority inside the entry: rst > clear > load > drop.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int PC_W   = WORD_W,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      // Flushed control must never leak downstream; pc/data may keep stale values.
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      data  <= d_data;
      ctrl  <= d_ctrl;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional skid entry,
// freeze/flush control and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PC_W   = WORD_W,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t state, state_nxt;

  logic              main_valid, skid_valid;
  logic [PC_W-1:0]   main_pc, skid_pc, main_d_pc;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;

  logic accept, take;
  logic main_load, main_drop, skid_load, skid_drop;
  logic stalled;

  assign out_valid = main_valid & ~freeze;
  assign out_pc    = main_pc;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (take && accept) begin
          main_load = 1'b1;
        end else if (take) begin
          main_drop = 1'b1;
          state_nxt = ST_EMPTY;
        end else if (accept && (SKID != 0)) begin
          skid_load = 1'b1;
          state_nxt = ST_SKID;
        end
      end
      ST_SKID: begin
        if (take) begin
          main_load = 1'b1;
          skid_drop = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // Main refills from the skid entry first so acceptance order is preserved.
  assign main_d_pc   = (state == ST_SKID) ? skid_pc   : in_pc;
  assign main_d_data = (state == ST_SKID) ? skid_data : in_data;
  assign main_d_ctrl = (state == ST_SKID) ? skid_ctrl : in_ctrl;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  pipe_entry #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .load   (main_load),
    .drop   (main_drop),
    .d_pc   (main_d_pc),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (main_valid),
    .pc     (main_pc),
    .data   (main_data),
    .ctrl   (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (skid_load),
        .drop   (skid_drop),
        .d_pc   (in_pc),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (skid_valid),
        .pc     (skid_pc),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
      );
      // Ready depends only on held state, breaking the stage-to-stage ready chain.
      assign in_ready = ~skid_valid & ~freeze;
    end else begin : g_no_skid
      logic unused_skid;
      assign unused_skid = skid_load | skid_drop;
      assign skid_valid  = 1'b0;
      assign skid_pc     = '0;
      assign skid_data   = '0;
      assign skid_ctrl   = '0;
      assign in_ready    = (~main_valid | out_ready) & ~freeze;
    end
  endgenerate

  assign stalled = (main_valid & ~out_ready) | freeze;

  always_ff @(posedge clk) begin
    if (rst)                             stall_cnt <= '0;
    else if (stalled && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a SKID=1/CNT_W=4 and a SKID=0 instance share stimulus
// and are compared each cycle against queue-based reference models.
module tb_pipe_stage_reg;

  logic        clk, rst, freeze, flush, in_valid, out_ready;
  logic [31:0] in_pc;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_pc, b_out_pc;
  logic [63:0] a_out_data, b_out_data;
  logic [7:0]  a_out_ctrl, b_out_ctrl;
  logic [3:0]  a_stall;
  logic [15:0] b_stall;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    logic [7:0]  ctrl;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   ca = 0;
  int   cb = 0;
  logic [31:0] sb[$];

  pipe_stage_reg #(.PC_W(32), .DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.PC_W(32), .DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .stall_cnt(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ready_exp(input bit skid, input int n);
    if (skid) return (n < 2) && !freeze;
    return ((n == 0) || out_ready) && !freeze;
  endfunction

  task automatic model_check();
    int n;
    bit ev;
    logic [7:0] ec;
    n  = qa.size();
    ev = (n > 0) && !freeze;
    ec = '0;
    if (ev) ec = qa[0].ctrl;
    chk("a_out_valid", 64'(a_out_valid), 64'(ev));
    chk("a_in_ready",  64'(a_in_ready),  64'(ready_exp(1'b1, n)));
    chk("a_out_ctrl",  64'(a_out_ctrl),  64'(ec));
    chk("a_stall_cnt", 64'(a_stall),     64'(ca));
    if (ev) begin
      chk("a_out_pc",   64'(a_out_pc), 64'(qa[0].pc));
      chk("a_out_data", a_out_data,    qa[0].data);
    end
    n  = qb.size();
    ev = (n > 0) && !freeze;
    ec = '0;
    if (ev) ec = qb[0].ctrl;
    chk("b_out_valid", 64'(b_out_valid), 64'(ev));
    chk("b_in_ready",  64'(b_in_ready),  64'(ready_exp(1'b0, n)));
    chk("b_out_ctrl",  64'(b_out_ctrl),  64'(ec));
    chk("b_stall_cnt", 64'(b_stall),     64'(cb));
    if (ev) begin
      chk("b_out_pc",   64'(b_out_pc), 64'(qb[0].pc));
      chk("b_out_data", b_out_data,    qb[0].data);
    end
  endtask

  // Reference behaviour: a bounded FIFO of held entries plus a stall counter.
  task automatic model_update();
    ent_t e;
    int   na, nb;
    bit   ta, aa, tb, ab;
    e  = '{pc: in_pc, data: in_data, ctrl: in_ctrl};
    na = qa.size();
    nb = qb.size();
    ta = (na > 0) && !freeze && out_ready;
    aa = in_valid && ready_exp(1'b1, na);
    tb = (nb > 0) && !freeze && out_ready;
    ab = in_valid && ready_exp(1'b0, nb);
    if (rst) begin
      qa.delete(); qb.delete(); ca = 0; cb = 0;
    end else begin
      if (((na > 0) && !out_ready) || freeze) if (ca < 15)    ca++;
      if (((nb > 0) && !out_ready) || freeze) if (cb < 65535) cb++;
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (ta) void'(qa.pop_front());
        if (aa) qa.push_back(e);
        if (tb) void'(qb.pop_front());
        if (ab) qb.push_back(e);
      end
    end
  endtask

  task automatic cycle();
    #4;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [7:0] ctrl, input bit ordy);
    in_valid  = v;
    in_pc     = pc;
    in_ctrl   = ctrl;
    in_data   = {$urandom, $urandom};
    out_ready = ordy;
    freeze    = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 8'h0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 32'h0, 8'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);
    chk("rst_stall",     64'(a_stall),     64'd0);
    chk("rst_out_ctrl",  64'(b_out_ctrl),  64'd0);
    cycle();

    // Streaming, no backpressure
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * i), 8'($urandom), 1'b1);
      cycle();
    end
    drive(1'b0, 32'h0, 8'h0, 1'b1);
    cycle();
    chk("stream_stall", 64'(a_stall), 64'd0);

    // Backpressure into the skid entry
    do_reset();
    drive(1'b1, 32'h10, 8'h11, 1'b0); cycle();
    drive(1'b1, 32'h14, 8'h22, 1'b0); cycle();
    drive(1'b0, 32'h0, 8'h0, 1'b1);
    #1;
    chk("bp_in_ready", 64'(a_in_ready), 64'd0);
    chk("bp_first",    64'(a_out_pc),   64'h10);
    cycle();
    #1;
    chk("bp_second",   64'(a_out_pc),   64'h14);
    cycle();
    cycle();
    chk("bp_stall", 64'(a_stall), 64'd1);

    // Freeze while FULL
    do_reset();
    drive(1'b1, 32'h20, 8'hA5, 1'b1); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(i), 8'h5A, 1'b1);
      freeze = 1'b1;
      #1;
      chk("frz_out_valid", 64'(a_out_valid), 64'd0);
      chk("frz_in_ready",  64'(a_in_ready),  64'd0);
      cycle();
    end
    drive(1'b0, 32'h0, 8'h0, 1'b1);
    #1;
    chk("frz_pc",    64'(a_out_pc),   64'h20);
    chk("frz_ctrl",  64'(a_out_ctrl), 64'hA5);
    chk("frz_stall", 64'(a_stall),    64'd3);
    cycle();

    // Flush from SKIDDED while frozen with input offered
    do_reset();
    drive(1'b1, 32'h30, 8'hFF, 1'b0); cycle();
    drive(1'b1, 32'h34, 8'hFF, 1'b0); cycle();
    drive(1'b1, 32'h99, 8'h77, 1'b0);
    flush  = 1'b1;
    freeze = 1'b1;
    cycle();
    drive(1'b0, 32'h0, 8'h0, 1'b1);
    #1;
    chk("fl_out_valid", 64'(a_out_valid), 64'd0);
    chk("fl_out_ctrl",  64'(a_out_ctrl),  64'd0);
    chk("fl_in_ready",  64'(a_in_ready),  64'd1);
    repeat (3) cycle();

    // Counter saturation on the 4-bit instance
    do_reset();
    drive(1'b1, 32'h50, 8'h01, 1'b0); cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h0, 8'h0, 1'b0);
      cycle();
    end
    chk("sat_stall", 64'(a_stall), 64'd15);
    do_reset();
    chk("sat_cleared", 64'(a_stall), 64'd0);

    // Single-entry build: ready follows out_ready, order preserved
    sb.delete();
    for (int i = 0; i < 11; i++) begin
      if (i < 9) drive(1'b1, 32'h100 + 32'(4 * i), 8'($urandom), (i % 2) == 0);
      else       drive(1'b0, 32'h0, 8'h0, 1'b1);
      #1;
      if (qb.size() > 0) chk("b_ready_follow", 64'(b_in_ready), 64'(out_ready));
      if (b_out_valid && out_ready) begin
        chk("b_sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) chk("b_order", 64'(b_out_pc), 64'(sb.pop_front()));
      end
      if (in_valid && b_in_ready) sb.push_back(in_pc);
      cycle();
    end
    chk("b_sb_drained", 64'(sb.size()), 64'd0);

    // Randomized traffic against the reference models
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom), $urandom_range(0, 2) != 0);
      freeze = ($urandom_range(0, 7) == 0);
      flush  = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
